memory_unit: RTL and testbench

- Word-addressed single-port data/program memory. It is the responder for the cpu memory interface: it accepts we/addr/data from the cpu and returns read data on mem.
- After reset it clears its array, then accepts a program image over a valid/ready loader port. Only then does it release the cpu from reset via cpu_rst_n.
- It sits between the testbench/top-level loader and the cpu.

---
 rtl/memory_unit.sv | 127 ++++++++++++
 tb/tb_memory_unit.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_unit.sv
// ============================================================================
// Module   : memory_unit
// Brief    : Word-addressed single-port memory; self-clears, accepts a loader
//            image, then releases the cpu and serves its read/write port.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module memory_unit #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 2**ADDR_WIDTH,
    parameter int LOAD_BASE  = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] data,
    output logic [DATA_WIDTH-1:0] mem,
    input  logic                  ld_valid,
    input  logic [DATA_WIDTH-1:0] ld_data,
    input  logic                  ld_last,
    output logic                  ld_ready,
    output logic                  cpu_rst_n,
    output logic                  busy
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] C_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH-1:0] C_LOAD_BASE = ADDR_WIDTH'(LOAD_BASE);
    localparam logic [ADDR_WIDTH:0]   C_LD_CAP    = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   clr_cnt_q, clr_cnt_d;
    logic [ADDR_WIDTH-1:0]   ld_ptr_q, ld_ptr_d;
    logic [ADDR_WIDTH:0]     ld_cnt_q, ld_cnt_d;
    logic [DATA_WIDTH-1:0]   mem_q, mem_d;
    logic                    cpu_rst_n_q;
    logic [DATA_WIDTH-1:0]   array_q [DEPTH];

    logic                    wr_en;
    logic [ADDR_WIDTH-1:0]   wr_addr;
    logic [DATA_WIDTH-1:0]   wr_data;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_cnt_q   <= '0;
            ld_ptr_q    <= C_LOAD_BASE;
            ld_cnt_q    <= '0;
            mem_q       <= '0;
            cpu_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            ld_ptr_q    <= ld_ptr_d;
            ld_cnt_q    <= ld_cnt_d;
            mem_q       <= mem_d;
            cpu_rst_n_q <= (state_q == ST_RUN);
        end
    end

    // All three phases share one write port; the FSM selects its source.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            array_q[wr_addr] <= wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ld_ptr_d  = ld_ptr_q;
        ld_cnt_d  = ld_cnt_q;
        mem_d     = '0;
        wr_en     = 1'b0;
        wr_addr   = clr_cnt_q;
        wr_data   = '0;

        case (state_q)
            ST_CLEAR: begin
                wr_en     = 1'b1;
                wr_addr   = clr_cnt_q;
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == C_LAST_ADDR) begin
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (ld_valid) begin
                    wr_en    = 1'b1;
                    wr_addr  = ld_ptr_q;
                    wr_data  = ld_data;
                    ld_ptr_d = ld_ptr_q + 1'b1;
                    ld_cnt_d = ld_cnt_q + 1'b1;
                    if (ld_last || (ld_cnt_d == C_LD_CAP)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                // Read-before-write: mem_d samples the array before this edge's write.
                mem_d   = array_q[addr];
                wr_en   = we;
                wr_addr = addr;
                wr_data = data;
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    assign mem       = mem_q;
    assign cpu_rst_n = cpu_rst_n_q;
    assign ld_ready  = (state_q == ST_LOAD);
    assign busy      = (state_q != ST_RUN);

endmodule

`default_nettype wire

// File: tb/tb_memory_unit.sv
// ============================================================================
// Module   : tb_memory_unit
// Brief    : Self-checking bench for memory_unit; two instances (LOAD_BASE 0
//            and 60) driven in lockstep against an array reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_memory_unit;

    logic        clk;
    logic        rst_n;
    logic        we;
    logic [5:0]  addr;
    logic [15:0] data;
    logic        ld_valid;
    logic [15:0] ld_data;
    logic        ld_last;

    logic [15:0] mem_a, mem_b;
    logic        ld_ready_a, ld_ready_b;
    logic        cpu_rst_n_a, cpu_rst_n_b;
    logic        busy_a, busy_b;

    memory_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .LOAD_BASE(0)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .data(data),
        .mem(mem_a), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready_a), .cpu_rst_n(cpu_rst_n_a), .busy(busy_a)
    );

    memory_unit #(.DATA_WIDTH(16), .ADDR_WIDTH(6), .LOAD_BASE(60)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .we(we), .addr(addr), .data(data),
        .mem(mem_b), .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last),
        .ld_ready(ld_ready_b), .cpu_rst_n(cpu_rst_n_b), .busy(busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: plain word arrays plus load progress.
    logic [15:0] ref_a [64];
    logic [15:0] ref_b [64];
    int          ld_cnt;
    bit          run_m;
    int          n_chk;
    int          n_pass;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    endtask

    task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_chk = n_chk + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic chk_status(input string tag, input logic rdy, input logic bsy,
                              input logic crst);
        chk1({tag, ".ld_ready_a"},  ld_ready_a,  rdy);
        chk1({tag, ".ld_ready_b"},  ld_ready_b,  rdy);
        chk1({tag, ".busy_a"},      busy_a,      bsy);
        chk1({tag, ".busy_b"},      busy_b,      bsy);
        chk1({tag, ".cpu_rst_n_a"}, cpu_rst_n_a, crst);
        chk1({tag, ".cpu_rst_n_b"}, cpu_rst_n_b, crst);
    endtask

    task automatic chk_mem(input string tag, input logic [15:0] ea, input logic [15:0] eb);
        chk16({tag, ".mem_a"}, mem_a, ea);
        chk16({tag, ".mem_b"}, mem_b, eb);
    endtask

    // Assert reset from any state, check it acts without a clock edge, then
    // walk the whole clear phase with garbage on every other input.
    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        chk_status("rst_async", 1'b0, 1'b1, 1'b0);
        chk_mem("rst_async", 16'h0000, 16'h0000);
        for (int i = 0; i < 64; i++) begin
            ref_a[i] = 16'h0000;
            ref_b[i] = 16'h0000;
        end
        ld_cnt = 0;
        run_m  = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        for (int c = 0; c < 64; c++) begin
            we       = 1'($urandom);
            addr     = 6'($urandom);
            data     = 16'($urandom);
            ld_valid = 1'($urandom);
            ld_data  = 16'($urandom);
            ld_last  = 1'($urandom);
            chk_status("clear", 1'b0, 1'b1, 1'b0);
            chk_mem("clear", 16'h0000, 16'h0000);
            tick();
        end
        we       = 1'b0;
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        chk_status("load_entry", 1'b1, 1'b1, 1'b0);
    endtask

    task automatic load_word(input logic [15:0] d, input logic last, input int gap);
        for (int g = 0; g < gap; g++) begin
            ld_valid = 1'b0;
            ld_last  = 1'($urandom);
            ld_data  = 16'($urandom);
            we       = 1'($urandom);
            addr     = 6'($urandom);
            data     = 16'($urandom);
            chk_status("load_gap", 1'b1, 1'b1, 1'b0);
            chk_mem("load_gap", 16'h0000, 16'h0000);
            tick();
        end
        we       = 1'b0;
        addr     = 6'd0;
        ld_valid = 1'b1;
        ld_data  = d;
        ld_last  = last;
        chk_status("load_hs", 1'b1, 1'b1, 1'b0);
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        ld_data  = 16'($urandom);
        ref_a[ld_cnt % 64]        = d;
        ref_b[(60 + ld_cnt) % 64] = d;
        ld_cnt = ld_cnt + 1;
        if (last || ld_cnt == 64) run_m = 1'b1;
        chk_status("load_post", !run_m, !run_m, 1'b0);
        chk_mem("load_post", 16'h0000, 16'h0000);
        if (run_m) begin
            tick();
            chk_status("run_entry", 1'b0, 1'b0, 1'b1);
            chk_mem("run_entry", ref_a[0], ref_b[0]);
        end
    endtask

    task automatic cpu_op(input logic w, input logic [5:0] a, input logic [15:0] d);
        logic [15:0] exp_a;
        logic [15:0] exp_b;
        we       = w;
        addr     = a;
        data     = d;
        ld_valid = 1'($urandom);
        ld_data  = 16'($urandom);
        ld_last  = 1'($urandom);
        tick();
        exp_a = ref_a[a];
        exp_b = ref_b[a];
        if (w) begin
            ref_a[a] = d;
            ref_b[a] = d;
        end
        chk_mem("cpu_op", exp_a, exp_b);
        chk_status("cpu_op", 1'b0, 1'b0, 1'b1);
        we       = 1'b0;
        ld_valid = 1'b0;
    endtask

    initial begin
        int n;
        n_chk    = 0;
        n_pass   = 0;
        rst_n    = 1'b1;
        we       = 1'b0;
        addr     = 6'd0;
        data     = 16'h0000;
        ld_valid = 1'b0;
        ld_data  = 16'h0000;
        ld_last  = 1'b0;
        tick();

        // Short program with gaps, then directed reads and a read-before-write.
        do_reset();
        load_word(16'h1234, 1'b0, 2);
        load_word(16'hABCD, 1'b0, 3);
        load_word(16'h0F0F, 1'b1, 1);
        cpu_op(1'b0, 6'd1,  16'h0000);
        cpu_op(1'b0, 6'd10, 16'h0000);
        cpu_op(1'b1, 6'd5,  16'h5555);
        cpu_op(1'b0, 6'd5,  16'h0000);
        cpu_op(1'b0, 6'd61, 16'h0000);
        for (int i = 0; i < 40; i++) begin
            cpu_op(1'($urandom), 6'($urandom), 16'($urandom));
        end

        // Reset from RUN, then a full 64-word image with no ld_last.
        do_reset();
        for (int i = 0; i < 64; i++) begin
            logic [15:0] v;
            v = 16'(i) ^ 16'hA5A5;
            load_word(v, 1'b0, int'($urandom_range(0, 1)));
        end
        for (int i = 0; i < 64; i++) begin
            cpu_op(1'b0, 6'(i), 16'h0000);
        end

        // Reset mid-load, then a single-word reload.
        do_reset();
        load_word(16'h1111, 1'b0, 1);
        load_word(16'h2222, 1'b0, 0);
        ld_valid = 1'b1;
        ld_data  = 16'h7777;
        do_reset();
        load_word(16'h3333, 1'b1, 2);
        cpu_op(1'b0, 6'd1, 16'h0000);
        cpu_op(1'b0, 6'd0, 16'h0000);
        cpu_op(1'b0, 6'd60, 16'h0000);

        // Random image with ld_last, then random traffic.
        do_reset();
        n = int'($urandom_range(1, 8));
        for (int i = 0; i < n; i++) begin
            load_word(16'($urandom), (i == n - 1), int'($urandom_range(0, 2)));
        end
        for (int i = 0; i < 80; i++) begin
            cpu_op(1'($urandom), 6'($urandom), 16'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
